// File: rtl/tff_bank.sv
// Multi-mode (T/D/JK/SR) flip-flop bank with parallel load, enable, per-bit change flags,
// a saturating change counter and a sticky SR-illegal flag.
module tff_bank #(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      CNT_W   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] changed,
  output logic [CNT_W-1:0] chg_cnt,
  output logic             sr_err
);

  typedef enum logic [1:0] {ModeT, ModeD, ModeJk, ModeSr} mode_e;

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] diff;
  logic             err_set;

  always_comb begin
    q_d     = q;
    err_set = 1'b0;
    if (load) begin
      q_d = load_val;
    end else if (en) begin
      unique case (mode_e'(mode))
        ModeT:  q_d = q ^ a;
        ModeD:  q_d = a;
        ModeJk: q_d = (a & ~q) | (~b & q);
        ModeSr: begin
          // S=R=1 is illegal and holds, same as S=R=0.
          q_d     = (a & ~b) | (q & ~(a ^ b));
          err_set = |(a & b);
        end
      endcase
    end
  end

  assign diff = q_d ^ q;
  assign qb   = ~q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= RST_VAL;
      changed <= '0;
      chg_cnt <= '0;
      sr_err  <= 1'b0;
    end else begin
      q       <= q_d;
      changed <= diff;
      if ((|diff) && !(&chg_cnt)) begin
        chg_cnt <= chg_cnt + 1'b1;
      end
      // A new illegal edge takes priority over a clear in the same cycle.
      if (err_set) begin
        sr_err <= 1'b1;
      end else if (clr_err) begin
        sr_err <= 1'b0;
      end
    end
  end

endmodule
